digit_countdown_timer: RTL and testbench

DIGIT_COUNTDOWN_TIMER -- requirements
Module: digit_countdown_timer

---
 rtl/digit_timer_pkg.sv | 14 +
 rtl/tick_divider.sv | 41 ++++
 rtl/digit_countdown_timer.sv | 87 ++++++++
 tb/tb_digit_countdown_timer.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/digit_timer_pkg.sv
// Shared constants for the digit countdown timer: direction encodings
// and default parameter values.
package digit_timer_pkg;

  localparam logic DIR_DOWN = 1'b0;
  localparam logic DIR_UP   = 1'b1;

  localparam int unsigned DEF_DIV_MAX     = 9;
  localparam int unsigned DEF_DIV_WIDTH   = 23;
  localparam int unsigned DEF_DIGIT_WIDTH = 4;
  localparam int unsigned DEF_DIGIT_MAX   = 9;
  localparam logic        DEF_DIRECTION   = DIR_DOWN;

endpackage : digit_timer_pkg

// File: rtl/tick_divider.sv
// Free-running divider: counts 0..DIV_MAX and asserts pulse for the one
// cycle in which the counter sits at DIV_MAX.
module tick_divider
  import digit_timer_pkg::*;
#(
  parameter int unsigned DIV_MAX   = DEF_DIV_MAX,
  parameter int unsigned DIV_WIDTH = DEF_DIV_WIDTH
) (
  input  logic clk,
  input  logic reset,
  output logic pulse
);

  localparam logic [DIV_WIDTH-1:0] DIV_LAST = DIV_WIDTH'(DIV_MAX);

  logic [DIV_WIDTH-1:0] div_q;
  logic [DIV_WIDTH-1:0] div_d;

  // Next divider value: wrap to zero after the terminal count.
  always_comb begin
    div_d = div_q + 1'b1;
    if (div_q == DIV_LAST) begin
      div_d = '0;
    end
  end

  // Divider register with synchronous clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      div_q <= '0;
    end else begin
      div_q <= div_d;
    end
  end

  // Tick is a decode of the divider state.
  always_comb begin
    pulse = (div_q == DIV_LAST);
  end

endmodule : tick_divider

// File: rtl/digit_countdown_timer.sv
// Single-digit up/down timer stepped by a divided tick.
// Optional build macro: DIGIT_HOLD_AT_TERM_EN -- when defined the digit
// stops at its terminal value instead of wrapping.
module digit_countdown_timer
  import digit_timer_pkg::*;
#(
  parameter int unsigned DIV_MAX     = DEF_DIV_MAX,
  parameter int unsigned DIV_WIDTH   = DEF_DIV_WIDTH,
  parameter int unsigned DIGIT_WIDTH = DEF_DIGIT_WIDTH,
  parameter int unsigned DIGIT_MAX   = DEF_DIGIT_MAX,
  parameter logic        DIRECTION   = DEF_DIRECTION
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   load,
  input  logic [DIGIT_WIDTH-1:0] start_count,
  output logic                   pulse,
  output logic [DIGIT_WIDTH-1:0] count,
  output logic                   term_count
);

  localparam logic [DIGIT_WIDTH-1:0] DIGIT_TOP = DIGIT_WIDTH'(DIGIT_MAX);
  // Value the digit takes after stepping past its terminal value.
  localparam logic [DIGIT_WIDTH-1:0] WRAP_TGT  =
    (DIRECTION == DIR_UP) ? '0 : DIGIT_TOP;

  logic [DIGIT_WIDTH-1:0] count_q;
  logic [DIGIT_WIDTH-1:0] count_d;
  logic                   term;

  tick_divider #(
    .DIV_MAX   (DIV_MAX),
    .DIV_WIDTH (DIV_WIDTH)
  ) u_tick_divider (
    .clk   (clk),
    .reset (reset),
    .pulse (pulse)
  );

  // Terminal detect depends only on the current digit and direction.
  always_comb begin
    if (DIRECTION == DIR_UP) begin
      term = (count_q == DIGIT_TOP);
    end else begin
      term = (count_q == '0);
    end
  end

  // Next digit: load beats tick beats hold; reset is applied in the register.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = (start_count > DIGIT_TOP) ? DIGIT_TOP : start_count;
    end else if (pulse) begin
      if (count_q > DIGIT_TOP) begin
        // Out-of-range digit is pulled back to the wrap target.
        count_d = WRAP_TGT;
      end else if (term) begin
`ifdef DIGIT_HOLD_AT_TERM_EN
        count_d = count_q;
`else
        count_d = WRAP_TGT;
`endif
      end else if (DIRECTION == DIR_UP) begin
        count_d = count_q + 1'b1;
      end else begin
        count_d = count_q - 1'b1;
      end
    end
  end

  // Digit register with synchronous clear (overrides load).
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Output drive.
  always_comb begin
    count      = count_q;
    term_count = term;
  end

endmodule : digit_countdown_timer

// File: tb/tb_digit_countdown_timer.sv
// Directed bench: a default down-counting instance and an up-counting
// instance with DIGIT_MAX=5 share clock and reset.
module tb_digit_countdown_timer;

  logic       clk;
  logic       reset;
  logic       load0, load1;
  logic [3:0] start0, start1;
  logic       pulse0, pulse1;
  logic [3:0] count0, count1;
  logic       term0, term1;

  int total = 0;
  int bad   = 0;

  logic [3:0] m0;
  logic [3:0] m1;
  int         npulse;

  digit_countdown_timer dut_dn (
    .clk         (clk),
    .reset       (reset),
    .load        (load0),
    .start_count (start0),
    .pulse       (pulse0),
    .count       (count0),
    .term_count  (term0)
  );

  digit_countdown_timer #(
    .DIGIT_MAX (5),
    .DIRECTION (1'b1)
  ) dut_up (
    .clk         (clk),
    .reset       (reset),
    .load        (load1),
    .start_count (start1),
    .pulse       (pulse1),
    .count       (count1),
    .term_count  (term1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [3:0] step_dn(input logic [3:0] c);
`ifdef DIGIT_HOLD_AT_TERM_EN
    return (c == 4'd0) ? 4'd0 : c - 4'd1;
`else
    return (c == 4'd0) ? 4'd9 : c - 4'd1;
`endif
  endfunction

  function automatic logic [3:0] step_up(input logic [3:0] c);
`ifdef DIGIT_HOLD_AT_TERM_EN
    return (c == 4'd5) ? 4'd5 : c + 4'd1;
`else
    return (c == 4'd5) ? 4'd0 : c + 4'd1;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance until pulse is high (bounded), then take the stepping edge.
  task automatic wait_pulse_and_step();
    int n;
    n = 0;
    while (pulse0 !== 1'b1 && n < 30) begin
      tick();
      n++;
    end
    chk("pulse_seen", {31'd0, pulse0}, 32'd1);
    tick();
  endtask

  // Check the pulse train for the first 10 cycles after reset release.
  task automatic check_period(input string tag);
    for (int c = 1; c <= 10; c++) begin
      chk(tag, {31'd0, pulse0}, (c == 10) ? 32'd1 : 32'd0);
      chk({tag, "_up"}, {31'd0, pulse1}, (c == 10) ? 32'd1 : 32'd0);
      if (c < 10) tick();
    end
  endtask

  initial begin
    reset = 1'b1; load0 = 1'b0; load1 = 1'b0; start0 = '0; start1 = '0;
    tick();
    chk("rst_count_dn", {28'd0, count0}, 32'd0);
    chk("rst_term_dn",  {31'd0, term0},  32'd1);
    chk("rst_pulse",    {31'd0, pulse0}, 32'd0);
    chk("rst_count_up", {28'd0, count1}, 32'd0);
    chk("rst_term_up",  {31'd0, term1},  32'd0);

    // Pulse arrives in the 10th cycle after release.
    reset = 1'b0;
    check_period("first_period");

    // Free-running countdown through a full wrap; up instance alongside.
    m0 = 4'd0; m1 = 4'd0;
    for (int k = 0; k <= 10; k++) begin
      wait_pulse_and_step();
      m0 = step_dn(m0);
      m1 = step_up(m1);
      chk("run_count_dn", {28'd0, count0}, {28'd0, m0});
      chk("run_term_dn",  {31'd0, term0},  (m0 == 4'd0) ? 32'd1 : 32'd0);
      chk("run_count_up", {28'd0, count1}, {28'd0, m1});
      chk("run_term_up",  {31'd0, term1},  (m1 == 4'd5) ? 32'd1 : 32'd0);
    end

    // One-cycle load of 2, then three ticks.
    load0 = 1'b1; start0 = 4'd2;
    tick();
    load0 = 1'b0;
    m0 = 4'd2;
    chk("load_count", {28'd0, count0}, 32'd2);
    chk("load_term",  {31'd0, term0},  32'd0);
    for (int k = 0; k < 3; k++) begin
      wait_pulse_and_step();
      m0 = step_dn(m0);
      chk("after_load_count", {28'd0, count0}, {28'd0, m0});
      chk("after_load_term",  {31'd0, term0},  (m0 == 4'd0) ? 32'd1 : 32'd0);
    end

    // Held load across two ticks keeps the digit pinned.
    load0 = 1'b1; start0 = 4'd2;
    npulse = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (pulse0 === 1'b1) npulse++;
      chk("held_load_count", {28'd0, count0}, 32'd2);
    end
    chk("held_load_pulses", npulse, 32'd2);
    load0 = 1'b0;
    wait_pulse_and_step();
    chk("resume_count", {28'd0, count0}, 32'd1);

    // Load 5, reset mid-period with a competing load.
    load0 = 1'b1; start0 = 4'd5;
    tick();
    load0 = 1'b0;
    chk("preload5", {28'd0, count0}, 32'd5);
    tick(); tick(); tick();
    reset = 1'b1; load0 = 1'b1; start0 = 4'd7;
    tick();
    chk("midrst_count", {28'd0, count0}, 32'd0);
    chk("midrst_pulse", {31'd0, pulse0}, 32'd0);
    chk("midrst_term",  {31'd0, term0},  32'd1);
    reset = 1'b0; load0 = 1'b0;
    check_period("midrst_period");
    tick();
    chk("midrst_next", {28'd0, count0}, {28'd0, step_dn(4'd0)});

    // Up instance: oversize load clamps to DIGIT_MAX, then one tick.
    load1 = 1'b1; start1 = 4'd7;
    tick();
    load1 = 1'b0;
    chk("clamp_count", {28'd0, count1}, 32'd5);
    chk("clamp_term",  {31'd0, term1},  32'd1);
    wait_pulse_and_step();
    chk("clamp_next", {28'd0, count1}, {28'd0, step_up(4'd5)});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global time bound so the run always terminates.
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule : tb_digit_countdown_timer
